// File: rtl/bicubic_pkg.sv
// Shared constants and FSM state type for the bicubic 4x upscaler phase sequencer.
package bicubic_pkg;

  localparam int PHASE_W       = 2;
  localparam int SCALE         = 4;
  localparam int DEFAULT_DIM_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/bicubic_phase_sequencer.sv
// Walks every (src_y, iy, src_x, ix) phase beat of one upscaled frame and hands
// the window centre plus weight-ROM phase address downstream under valid/ready.
module bicubic_phase_sequencer
  import bicubic_pkg::*;
#(
  parameter int DIM_W = DEFAULT_DIM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   src_width,
  input  logic [DIM_W-1:0]   src_height,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PHASE_W-1:0] ix,
  output logic [PHASE_W-1:0] iy,
  output logic [DIM_W-1:0]   src_x,
  output logic [DIM_W-1:0]   src_y,
  output logic               sof,
  output logic               eol,
  output logic               eof
);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SCALE - 1);

  seq_state_t         state;
  logic [DIM_W-1:0]   width_lat;
  logic [DIM_W-1:0]   height_lat;

  logic               ix_last, iy_last, sx_last, sy_last;
  logic [PHASE_W-1:0] next_ix, next_iy;
  logic [DIM_W-1:0]   next_sx, next_sy;
  logic               next_eol, next_eof;

  // Nested wrap/carry of the four counters, plus the line/frame flags of the
  // beat that follows, so those flags can be registered alongside it.
  always_comb begin
    ix_last  = (ix == PHASE_LAST);
    iy_last  = (iy == PHASE_LAST);
    sx_last  = (src_x == width_lat - DIM_W'(1));
    sy_last  = (src_y == height_lat - DIM_W'(1));
    next_ix  = ix_last ? '0 : ix + PHASE_W'(1);
    next_sx  = src_x;
    next_iy  = iy;
    next_sy  = src_y;
    if (ix_last) begin
      next_sx = sx_last ? '0 : src_x + DIM_W'(1);
      if (sx_last) begin
        next_iy = iy_last ? '0 : iy + PHASE_W'(1);
        if (iy_last) begin
          next_sy = sy_last ? '0 : src_y + DIM_W'(1);
        end
      end
    end
    next_eol = (next_sx == width_lat - DIM_W'(1)) && (next_ix == PHASE_LAST);
    next_eof = next_eol && (next_sy == height_lat - DIM_W'(1)) && (next_iy == PHASE_LAST);
  end

  // A zero-sized frame spends an extra DONE cycle with done low so the pulse
  // lands one cycle after busy rises; a real frame enters DONE with done set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      width_lat  <= '0;
      height_lat <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      ix         <= '0;
      iy         <= '0;
      src_x      <= '0;
      src_y      <= '0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            width_lat  <= src_width;
            height_lat <= src_height;
            busy       <= 1'b1;
            ix         <= '0;
            iy         <= '0;
            src_x      <= '0;
            src_y      <= '0;
            eol        <= 1'b0;
            eof        <= 1'b0;
            if (src_width == '0 || src_height == '0) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              sof       <= 1'b0;
            end else begin
              state     <= ST_RUN;
              out_valid <= 1'b1;
              sof       <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (out_valid && out_ready) begin
            if (eof) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
              ix        <= '0;
              iy        <= '0;
              src_x     <= '0;
              src_y     <= '0;
              sof       <= 1'b0;
              eol       <= 1'b0;
              eof       <= 1'b0;
            end else begin
              ix    <= next_ix;
              iy    <= next_iy;
              src_x <= next_sx;
              src_y <= next_sy;
              sof   <= 1'b0;
              eol   <= next_eol;
              eof   <= next_eof;
            end
          end
        end
        ST_DONE: begin
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_phase_sequencer.sv
// Self-checking bench: table of frames plus randomized ones compared beat by beat
// against a loop-built reference beat list, and hand sequences for corner cases.
module tb_bicubic_phase_sequencer;

  localparam int DIM_W = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [DIM_W-1:0] src_width = '0;
  logic [DIM_W-1:0] src_height = '0;
  logic             out_ready = 1'b0;
  logic             busy, done, out_valid, sof, eol, eof;
  logic [1:0]       ix, iy;
  logic [DIM_W-1:0] src_x, src_y;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int w;
    int h;
    int ready_pct;
    bit disturb;
    int exp_beats;
  } vec_t;

  typedef struct {
    int sx;
    int sy;
    int ix;
    int iy;
    int sof;
    int eol;
    int eof;
  } beat_t;

  bicubic_phase_sequencer #(.DIM_W(DIM_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_width  (src_width),
    .src_height (src_height),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ix         (ix),
    .iy         (iy),
    .src_x      (src_x),
    .src_y      (src_y),
    .sof        (sof),
    .eol        (eol),
    .eof        (eof)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] beatKey(int f_sof, int f_eol, int f_eof,
                                          int p_iy, int p_ix, int c_sy, int c_sx);
    logic [63:0] k;
    k = '0;
    k[15:0]  = c_sx[15:0];
    k[31:16] = c_sy[15:0];
    k[33:32] = p_ix[1:0];
    k[35:34] = p_iy[1:0];
    k[36]    = f_sof[0];
    k[37]    = f_eol[0];
    k[38]    = f_eof[0];
    return k;
  endfunction

  function automatic logic [63:0] dutKey();
    return beatKey(int'(sof), int'(eol), int'(eof), int'(iy), int'(ix),
                   int'(src_y), int'(src_x));
  endfunction

  // Reference order: rows, then vertical phase, then columns, then horizontal phase.
  task automatic buildModel(input int w, input int h, output beat_t q[$]);
    beat_t b;
    int n;
    q = {};
    n = 0;
    for (int y = 0; y < h; y++)
      for (int py = 0; py < 4; py++)
        for (int x = 0; x < w; x++)
          for (int px = 0; px < 4; px++) begin
            b.sx  = x;
            b.sy  = y;
            b.ix  = px;
            b.iy  = py;
            b.sof = (n == 0) ? 1 : 0;
            b.eol = (x == w - 1 && px == 3) ? 1 : 0;
            b.eof = (b.eol == 1 && y == h - 1 && py == 3) ? 1 : 0;
            q.push_back(b);
            n++;
          end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    beat_t q[$];
    int idx;
    int cyc;
    int budget;
    bit finished;
    buildModel(v.w, v.h, q);
    idx = 0;
    cyc = 0;
    finished = 1'b0;
    budget = v.exp_beats * 50 + 20;
    @(negedge clk);
    src_width  = DIM_W'(v.w);
    src_height = DIM_W'(v.h);
    out_ready  = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    while (!finished && cyc < budget) begin
      if (idx < q.size()) begin
        checkOutput("out_valid", 64'(out_valid), 64'd1);
        checkOutput("beat", dutKey(), beatKey(q[idx].sof, q[idx].eol, q[idx].eof,
                    q[idx].iy, q[idx].ix, q[idx].sy, q[idx].sx));
        checkOutput("done_low_in_run", 64'(done), 64'd0);
        out_ready = ($urandom_range(99) < v.ready_pct);
        if (out_ready) idx++;
        if (v.disturb && ($urandom_range(3) == 0)) begin
          start      = 1'b1;
          src_width  = DIM_W'($urandom_range(7));
          src_height = DIM_W'($urandom_range(7));
        end else begin
          start = 1'b0;
        end
      end else begin
        start     = 1'b0;
        out_ready = 1'b0;
        checkOutput("done_pulse", {61'd0, done, busy, out_valid}, 64'b110);
        finished = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (!finished) begin
      mismatched++;
      $display("[TB] FAIL timeout: %0d of %0d beats accepted in %0d cycles", idx, v.exp_beats, cyc);
    end
    compared++;
    checkOutput("beat_count", 64'(idx), 64'(v.exp_beats));
    checkOutput("idle_after_done", {62'd0, done, busy}, 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_state", {busy, done, out_valid, sof, eol, eof, ix, iy, src_x, src_y}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{1, 1, 100, 1'b0, 16});
    vecs.push_back('{2, 1, 100, 1'b0, 32});
    vecs.push_back('{3, 2, 50,  1'b0, 96});
    vecs.push_back('{2, 3, 70,  1'b1, 96});
    vecs.push_back('{4, 2, 60,  1'b1, 128});
    for (int r = 0; r < 3; r++) begin
      vec_t rv;
      rv.w = $urandom_range(1, 5);
      rv.h = $urandom_range(1, 3);
      rv.ready_pct = $urandom_range(30, 90);
      rv.disturb = $urandom_range(1);
      rv.exp_beats = 16 * rv.w * rv.h;
      vecs.push_back(rv);
    end
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Zero-width frame: no beats, done one cycle after busy.
    @(negedge clk);
    src_width  = DIM_W'(0);
    src_height = DIM_W'(5);
    out_ready  = 1'b1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("zero_busy", {61'd0, done, busy, out_valid}, 64'b010);
    @(negedge clk);
    checkOutput("zero_done", {61'd0, done, busy, out_valid}, 64'b110);
    @(negedge clk);
    checkOutput("zero_idle", {61'd0, done, busy, out_valid}, 64'b000);

    // Reset at beat 10 of a 2x2 frame.
    begin
      beat_t q[$];
      buildModel(2, 2, q);
      @(negedge clk);
      src_width  = DIM_W'(2);
      src_height = DIM_W'(2);
      out_ready  = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
        checkOutput("pre_reset_beat", dutKey(), beatKey(q[i].sof, q[i].eol, q[i].eof,
                    q[i].iy, q[i].ix, q[i].sy, q[i].sx));
        if (i < 9) @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      checkOutput("async_reset", {busy, done, out_valid, sof, eol, eof, ix, iy, src_x, src_y}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checkOutput("no_done_after_abort", {61'd0, done, busy, out_valid}, 64'd0);
      end
    end
    applyStimulus('{2, 2, 100, 1'b0, 64});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
